// File: rtl/seg_pkg.sv
// Shared 7-segment glyph constants (active-low gfedcba) used by both the
// display encoder and the scan decoder, so the two directions cannot diverge.
package seg_pkg;

   localparam int unsigned SEG_W = 7;
   localparam int unsigned BCD_W = 4;

   localparam logic [SEG_W-1:0] SEG_0     = 7'h40;
   localparam logic [SEG_W-1:0] SEG_1     = 7'h79;
   localparam logic [SEG_W-1:0] SEG_2     = 7'h24;
   localparam logic [SEG_W-1:0] SEG_3     = 7'h30;
   localparam logic [SEG_W-1:0] SEG_4     = 7'h19;
   localparam logic [SEG_W-1:0] SEG_5     = 7'h12;
   localparam logic [SEG_W-1:0] SEG_6     = 7'h02;
   localparam logic [SEG_W-1:0] SEG_7     = 7'h78;
   localparam logic [SEG_W-1:0] SEG_8     = 7'h00;
   localparam logic [SEG_W-1:0] SEG_9     = 7'h10;
   localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

   localparam logic [BCD_W-1:0] ERR_DIGIT = 4'hF;

   // Decoded glyph: BCD digit plus illegal-pattern flag
   typedef struct packed {
      logic             err;
      logic [BCD_W-1:0] digit;
   } seg_dec_t;

endpackage

// File: rtl/seg_scan_decoder_if.sv
// Display-bus sample side and recovered-frame side of the scan decoder.
interface seg_scan_decoder_if
   import seg_pkg::*;
#(
   parameter int unsigned DIGITS = 4
) ();

   logic [SEG_W-1:0]        iSEG;
   logic [DIGITS-1:0]       iAN;
   logic [BCD_W*DIGITS-1:0] oBCD;
   logic [DIGITS-1:0]       oERR;
   logic                    oVALID;

   modport master (
      output iSEG,
      output iAN,
      input  oBCD,
      input  oERR,
      input  oVALID
   );

   modport slave (
      input  iSEG,
      input  iAN,
      output oBCD,
      output oERR,
      output oVALID
   );

endinterface

// File: rtl/seg7_to_bcd.sv
// Combinational glyph-to-BCD decoder; anything outside 0-9 maps to ERR_DIGIT.
module seg7_to_bcd
   import seg_pkg::*;
(
   input  logic [SEG_W-1:0] seg,
   output seg_dec_t         dec_c
);

   always_comb begin
      dec_c = '{err: 1'b0, digit: 4'd0};
      case (seg)
         SEG_0:   dec_c.digit = 4'd0;
         SEG_1:   dec_c.digit = 4'd1;
         SEG_2:   dec_c.digit = 4'd2;
         SEG_3:   dec_c.digit = 4'd3;
         SEG_4:   dec_c.digit = 4'd4;
         SEG_5:   dec_c.digit = 4'd5;
         SEG_6:   dec_c.digit = 4'd6;
         SEG_7:   dec_c.digit = 4'd7;
         SEG_8:   dec_c.digit = 4'd8;
         SEG_9:   dec_c.digit = 4'd9;
         default: dec_c = '{err: 1'b1, digit: ERR_DIGIT};
      endcase
   end

endmodule

// File: rtl/seg_scan_decoder.sv
// Samples a multiplexed active-low 7-segment display, accepts each digit after
// STABLE identical samples and strobes oVALID once every digit has been seen.
module seg_scan_decoder
   import seg_pkg::*;
#(
   parameter int unsigned DIGITS = 4,
   parameter int unsigned STABLE = 4
) (
   input  logic              iCLK,
   input  logic              iRST_N,
   seg_scan_decoder_if.slave bus
);

   localparam int unsigned RUN_W = $clog2(STABLE + 1);
   localparam int unsigned SMP_W = DIGITS + SEG_W;
   localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int unsigned OUT_W = BCD_W * DIGITS;

   logic [SMP_W-1:0]  s1, s2, s3;
   logic [DIGITS-1:0] an_c;
   logic [SEG_W-1:0]  seg_c;
   logic              sel_c;
   logic              same_c;
   logic [IDX_W-1:0]  idx_c;
   logic [RUN_W-1:0]  run, run_nxt_c;
   logic              commit_c;
   logic              frame_done_c;
   logic [DIGITS-1:0] mask, mask_nxt_c;
   logic [OUT_W-1:0]  shadow_bcd, shadow_bcd_nxt_c;
   logic [DIGITS-1:0] shadow_err, shadow_err_nxt_c;
   seg_dec_t          dec_c;

   // Two-flop synchronizer; s3 keeps the previous s2 for the stability compare
   always_ff @(posedge iCLK) begin
      if (!iRST_N) begin
         s1 <= '1;
         s2 <= '1;
         s3 <= '1;
      end else begin
         s1 <= {bus.iAN, bus.iSEG};
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign an_c  = s2[SMP_W-1 -: DIGITS];
   assign seg_c = s2[SEG_W-1:0];

   seg7_to_bcd u_dec (
      .seg   (seg_c),
      .dec_c (dec_c)
   );

   // Select check, low-anode index and saturating run counter
   always_comb begin
      sel_c  = $onehot(~an_c);
      same_c = (s2 == s3);
      idx_c  = '0;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (!an_c[i]) idx_c = IDX_W'(i);
      end

      run_nxt_c = '0;
      if (sel_c) begin
         if (!same_c)                        run_nxt_c = RUN_W'(1);
         else if (run == RUN_W'(STABLE))     run_nxt_c = run;
         else                                run_nxt_c = run + RUN_W'(1);
      end

      // Commit only on the transition into STABLE, never while saturated
      commit_c = sel_c && (run_nxt_c == RUN_W'(STABLE))
                 && !(same_c && (run == RUN_W'(STABLE)));
   end

   // Shadow digit/error update and frame-completion detect
   always_comb begin
      shadow_bcd_nxt_c = shadow_bcd;
      shadow_err_nxt_c = shadow_err;
      mask_nxt_c       = mask;
      if (commit_c) begin
         for (int i = 0; i < int'(DIGITS); i++) begin
            if (idx_c == IDX_W'(i)) begin
               shadow_bcd_nxt_c[BCD_W*i +: BCD_W] = dec_c.digit;
               shadow_err_nxt_c[i]                = dec_c.err;
               mask_nxt_c[i]                      = 1'b1;
            end
         end
      end
      frame_done_c = commit_c && (&mask_nxt_c);
   end

   always_ff @(posedge iCLK) begin
      if (!iRST_N) begin
         run        <= '0;
         mask       <= '0;
         shadow_bcd <= '0;
         shadow_err <= '0;
         bus.oBCD   <= '0;
         bus.oERR   <= '0;
         bus.oVALID <= 1'b0;
      end else begin
         run        <= run_nxt_c;
         shadow_bcd <= shadow_bcd_nxt_c;
         shadow_err <= shadow_err_nxt_c;
         bus.oVALID <= frame_done_c;
         if (frame_done_c) begin
            bus.oBCD <= shadow_bcd_nxt_c;
            bus.oERR <= shadow_err_nxt_c;
            mask     <= '0;
         end else begin
            mask     <= mask_nxt_c;
         end
      end
   end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: table of 4-digit scans plus hand-written
// glitch, bad-select and reset sequences.
module tb_seg_scan_decoder;
   import seg_pkg::*;

   localparam int unsigned DIGITS = 4;
   localparam int unsigned STABLE = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   seg_scan_decoder_if #(.DIGITS(DIGITS)) bus ();

   seg_scan_decoder #(
      .DIGITS (DIGITS),
      .STABLE (STABLE)
   ) dut (
      .iCLK   (clk),
      .iRST_N (rst_n),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0][6:0] seg;
      int              hold;
      logic [15:0]     bcd;
      logic [3:0]      err;
      int              pulses;
   } vec_t;

   vec_t vecs[6];

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;
   int pulses      = 0;
   int last_pulse  = -1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Drive one sample for n cycles, counting oVALID pulses seen on negedges
   task automatic hold(input logic [3:0] an, input logic [6:0] seg, input int n);
      bus.iAN  = an;
      bus.iSEG = seg;
      repeat (n) begin
         @(negedge clk);
         cyc++;
         if (bus.oVALID) begin
            pulses++;
            last_pulse = cyc;
         end
      end
   endtask

   // Digits 3..0 in turn, then idle; c0 is the cycle the digit-0 drive began
   task automatic scan(input logic [3:0][6:0] seg, input int h, output int c0);
      c0 = 0;
      for (int i = 3; i >= 0; i--) begin
         if (i == 0) c0 = cyc;
         hold(4'(~(4'b1 << i)), seg[i], h);
      end
      hold(4'hF, SEG_BLANK, 8);
   endtask

   task automatic check_frame(input string name, input int c0, input int exp_pulses,
                              input logic [15:0] bcd, input logic [3:0] err);
      check({name, "_pulses"}, 32'(pulses), 32'(exp_pulses));
      if (exp_pulses == 1) check({name, "_timing"}, 32'(last_pulse), 32'(c0 + 6));
      check({name, "_bcd"}, 32'(bus.oBCD), 32'(bcd));
      check({name, "_err"}, 32'(bus.oERR), 32'(err));
   endtask

   initial begin
      int c0;

      vecs[0] = '{seg: {7'h24, 7'h79, 7'h30, 7'h40}, hold: 6, bcd: 16'h2130, err: 4'b0000, pulses: 1};
      vecs[1] = '{seg: {7'h40, 7'h79, 7'h24, 7'h30}, hold: 6, bcd: 16'h0123, err: 4'b0000, pulses: 1};
      vecs[2] = '{seg: {7'h19, 7'h55, 7'h02, 7'h7F}, hold: 6, bcd: 16'h4F6F, err: 4'b0101, pulses: 1};
      vecs[3] = '{seg: {7'h12, 7'h78, 7'h00, 7'h10}, hold: 4, bcd: 16'h5789, err: 4'b0000, pulses: 1};
      vecs[4] = '{seg: {7'h40, 7'h40, 7'h40, 7'h40}, hold: 3, bcd: 16'h5789, err: 4'b0000, pulses: 0};
      vecs[5] = '{seg: {7'h79, 7'h02, 7'h12, 7'h24}, hold: 5, bcd: 16'h1652, err: 4'b0000, pulses: 1};

      // Power-on reset with random inputs
      rst_n    = 1'b0;
      bus.iAN  = 4'($urandom);
      bus.iSEG = 7'($urandom);
      @(negedge clk);
      bus.iAN  = 4'($urandom);
      bus.iSEG = 7'($urandom);
      @(negedge clk);
      check("reset_bcd", 32'(bus.oBCD), 32'h0);
      check("reset_err", 32'(bus.oERR), 32'h0);
      check("reset_valid", 32'(bus.oVALID), 32'h0);
      rst_n  = 1'b1;
      pulses = 0;
      hold(4'hF, SEG_BLANK, 10);
      check("reset_idle_pulses", 32'(pulses), 32'h0);

      // Table of complete scans
      for (int v = 0; v < 6; v++) begin
         pulses = 0;
         scan(vecs[v].seg, vecs[v].hold, c0);
         check_frame($sformatf("vec%0d", v), c0, vecs[v].pulses, vecs[v].bcd, vecs[v].err);
      end

      // Glitch inside the digit-1 hold, digit 1 scanned last
      pulses = 0;
      hold(4'b0111, 7'h24, 6);
      hold(4'b1011, 7'h30, 6);
      hold(4'b1110, 7'h40, 6);
      hold(4'b1101, 7'h79, 2);
      hold(4'b1101, 7'h12, 3);
      c0 = cyc;
      hold(4'b1101, 7'h79, 6);
      hold(4'hF, SEG_BLANK, 8);
      check_frame("glitch", c0, 1, 16'h2310, 4'b0000);

      // Bad selects must neither commit nor disturb the partial mask
      pulses = 0;
      hold(4'b0111, 7'h00, 6);
      hold(4'b1011, 7'h19, 6);
      hold(4'b1101, 7'h02, 6);
      hold(4'b0011, 7'h12, 20);
      hold(4'b1100, 7'h12, 10);
      hold(4'hF, SEG_BLANK, 4);
      check("badsel_pulses", 32'(pulses), 32'h0);
      c0 = cyc;
      hold(4'b1110, 7'h78, 6);
      hold(4'hF, SEG_BLANK, 8);
      check_frame("badsel_done", c0, 1, 16'h8467, 4'b0000);

      // Reset in the middle of a frame discards the partial frame
      pulses = 0;
      hold(4'b1110, 7'h40, 6);
      hold(4'b1101, 7'h79, 6);
      hold(4'b1011, 7'h24, 6);
      rst_n = 1'b0;
      hold(4'hF, SEG_BLANK, 1);
      rst_n = 1'b1;
      check("midrst_bcd", 32'(bus.oBCD), 32'h0);
      check("midrst_err", 32'(bus.oERR), 32'h0);
      check("midrst_valid", 32'(bus.oVALID), 32'h0);
      hold(4'b0111, 7'h30, 6);
      hold(4'hF, SEG_BLANK, 8);
      check("midrst_partial_pulses", 32'(pulses), 32'h0);
      check("midrst_partial_bcd", 32'(bus.oBCD), 32'h0);

      pulses = 0;
      scan(vecs[0].seg, vecs[0].hold, c0);
      check_frame("midrst_rescan", c0, 1, 16'h2130, 4'b0000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/seg_scan_decoder.md
# seg_scan_decoder

Reader side of the active-low 7-segment display bus: samples a time-multiplexed 4-digit display (shared segment lines `gfedcba` plus per-digit active-low anode selects) and reconstructs the BCD value of every digit. Each digit is accepted only after its pattern has been stable for a programmable number of cycles. When all digits have been captured, the block emits a one-cycle frame strobe. It sits in test and loopback paths that observe the display driver output, or an external display, and hand the recovered digits to checking or logging logic.

## Interface
- `DIGITS`, 4: number of multiplexed digits; width of `iAN` and `oERR`.
- `STABLE`, 4: consecutive identical samples required to accept a digit; legal range 1..255.
- `iCLK` in 1: single clock; all logic is on the rising edge.
- `iRST_N` in 1: reset, synchronous, active-low.
- `iSEG` in 7: segment lines, active-low, bit order `gfedcba` (bit 6 = g).
- `iAN` in `DIGITS`: digit selects, active-low; bit i low means digit i is driven.
- `oBCD` out 4·`DIGITS`: recovered digits; digit i occupies `[4i+3:4i]`.
- `oERR` out `DIGITS`: per-digit flag, set when the accepted pattern is not a legal 0–9 glyph.
- `oVALID` out 1: one-cycle strobe; `oBCD` and `oERR` hold a new complete frame.

## Operation
- **Input synchronizer.** `iSEG` and `iAN` pass through a 2-flop synchronizer (`s1`, `s2`). The synchronizer resets to all ones, which is the idle/blank level.
- **Select check.** A sample is *selected* when `s2` of `iAN` has exactly one bit low. All-high (blanking) or multiple bits low is *unselected*.
- **Run counter.** Width is `$clog2(STABLE+1)`; saturates at `STABLE`. On each edge:
  - unselected → `run <= 0`
  - selected and `{AN,SEG}` equals the previous edge's `s2` value → `run <= sat(run+1)`
  - otherwise → `run <= 1`
- **Commit.** Occurs on the edge where `run` transitions to `STABLE`, exactly once per stable run. Commit actions:
  - decode the pattern into shadow digit i (i = index of the low `iAN` bit);
  - update shadow error bit i;
  - set `mask[i]`.
  - If the same digit re-commits before the frame completes, the newer value overwrites the older.
- **Decode table** (`SEG` hex → digit): 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7, 00→8, 10→9.
  - Any other pattern, including blank 7F, yields digit 4'hF with err=1.
- **Frame completion.** When a commit makes `mask` all ones, on that same edge:
  - `oBCD`/`oERR` are loaded from the shadow registers, including the digit just committed;
  - `oVALID <= 1`;
  - `mask <= 0`.
- **Output hold.** At all other edges `oVALID <= 0`. `oBCD`/`oERR` hold their last frame.
- **Reset values.** `iRST_N` low at any edge, including mid-run or mid-frame, sets:
  - `oBCD=0`, `oERR=0`, `oVALID=0`;
  - `mask=0`, `run=0`, shadow registers = 0;
  - synchronizer = all ones.
  - Partial frames are discarded.

## Timing
- Suppose the inputs change before edge k and stay constant. Then:
  - the new value is visible in `s2` after edge k+1;
  - `run` = 1 at edge k+2;
  - commit occurs at edge k+1+`STABLE`.
- If that commit completes the frame, `oVALID` is high for exactly the cycle following edge k+1+`STABLE`.
- With `STABLE=1`, every changed selected sample commits on its first edge in `s2`.
- A glitch shorter than `STABLE` cycles never commits. A change that returns to the old value restarts `run` at 1.
- Holding one digit indefinitely produces a single commit; a second commit requires an intervening change or an unselected cycle.
- No backpressure: a consumer that misses `oVALID` loses the frame strobe. `oBCD` remains readable until the next frame.

## Structure
- **Shared package `seg_pkg`:**
  - 7-bit glyph constants `SEG_0`..`SEG_9` and `SEG_BLANK` (active-low `gfedcba`);
  - `ERR_DIGIT = 4'hF`.
- The display driver's encoder uses the same constants, so the encode and decode directions cannot diverge.
- **Sub-module `seg7_to_bcd`:** purely combinational glyph → {digit, err} decoder built on the package constants. One instance, shared across digits on the committed sample.
- The top level holds the synchronizer, run counter, select check, shadow registers, mask, and output registers.

## Test plan
- **Reset values:** Assert `iRST_N`=0 for 2 cycles with random inputs → `oBCD`=0, `oERR`=0, `oVALID`=0; no `oVALID` for 10 cycles afterward with `iAN`=4'hF.
- **Full frame:** Scan digits 3,2,1,0 with glyphs 24,79,30,40, each held 6 cycles with `STABLE`=4 → one `oVALID` pulse exactly 5 cycles after the digit-0 hold begins; `oBCD`=16'h2130, `oERR`=0.
- **Glitch rejection:** Within a digit-1 hold of 79, insert a 3-cycle 12 glitch (`STABLE`=4) → no commit of 5; the frame completes with digit 1 = 1.
- **Illegal glyph:** Apply 7F and 55 on digits 0 and 2 → `oBCD` nibbles 0 and 2 = F; `oERR`=4'b0101.
- **Bad select:** Drive `iAN`=4'b0011 (two low) for 20 cycles → no commit, `mask` unchanged, no `oVALID`.
- **Reset mid-frame:** Commit digits 0–2, pulse `iRST_N` low for 1 cycle, then commit only digit 3 → no `oVALID`; a full new scan is required before the next strobe.
